// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: start bit 0, WIDTH data bits LSB first, stop bit 1.
// Define PISO_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module piso_tx #(
    parameter int WIDTH   = 4,
    parameter int BIT_CYC = 4
) (
    input  logic             clk,
    input  logic             r,
    input  logic             ld_valid,
    input  logic [WIDTH-1:0] D,
    output logic             ld_ready,
    output logic             sd,
    output logic             busy,
    output logic             tx_done
);
    localparam int CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'((BIT_CYC > 1) ? BIT_CYC - 2 : 0);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic ONE_CYC = (BIT_CYC == 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PISO_TX_PARITY_EN
        PAR,
`endif
        STOP
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [BIT_W-1:0] bit_reg;
    logic [WIDTH-1:0] shift_reg;
    logic             sd_reg;
    logic             busy_reg;
    logic             ready_reg;
    logic             done_reg;
`ifdef PISO_TX_PARITY_EN
    logic             parity_reg;
`endif

    logic accept;
    logic bit_end;

    assign accept  = ld_valid & ready_reg;
    assign bit_end = (cnt_reg == CNT_LAST);

    // Outputs are computed for the cycle after each edge, so ld_ready/tx_done
    // are raised one edge early to land on the last STOP cycle.
    always_ff @(posedge clk) begin
        if (r) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            sd_reg     <= 1'b1;
            busy_reg   <= 1'b0;
            ready_reg  <= 1'b0;
            done_reg   <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            ready_reg <= 1'b0;
            done_reg  <= 1'b0;
            cnt_reg   <= bit_end ? '0 : cnt_reg + CNT_W'(1);
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (accept) begin
                        shift_reg  <= D;
`ifdef PISO_TX_PARITY_EN
                        parity_reg <= ^D;
`endif
                        state_reg  <= START;
                        sd_reg     <= 1'b0;
                        busy_reg   <= 1'b1;
                    end else begin
                        ready_reg <= 1'b1;
                        sd_reg    <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_reg <= DATA;
                        bit_reg   <= '0;
                        sd_reg    <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_reg == BIT_LAST) begin
`ifdef PISO_TX_PARITY_EN
                            state_reg <= PAR;
                            sd_reg    <= parity_reg;
`else
                            state_reg <= STOP;
                            sd_reg    <= 1'b1;
                            ready_reg <= ONE_CYC;
                            done_reg  <= ONE_CYC;
`endif
                        end else begin
                            shift_reg <= shift_reg >> 1;
                            sd_reg    <= shift_reg[1];
                            bit_reg   <= bit_reg + BIT_W'(1);
                        end
                    end
                end
`ifdef PISO_TX_PARITY_EN
                PAR: begin
                    if (bit_end) begin
                        state_reg <= STOP;
                        sd_reg    <= 1'b1;
                        ready_reg <= ONE_CYC;
                        done_reg  <= ONE_CYC;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (accept) begin
                            shift_reg  <= D;
`ifdef PISO_TX_PARITY_EN
                            parity_reg <= ^D;
`endif
                            state_reg  <= START;
                            sd_reg     <= 1'b0;
                        end else begin
                            state_reg <= IDLE;
                            sd_reg    <= 1'b1;
                            busy_reg  <= 1'b0;
                            ready_reg <= 1'b1;
                        end
                    end else if (cnt_reg == CNT_PRE) begin
                        ready_reg <= 1'b1;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ld_ready = ready_reg;
    assign sd       = sd_reg;
    assign busy     = busy_reg;
    assign tx_done  = done_reg;
endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: one instance with BIT_CYC=4, one with BIT_CYC=1.
// Expected frames come from a hand-computed table (parity columns used when PISO_TX_PARITY_EN is set).
module tb_piso_tx;
    logic       clk = 1'b0;
    logic       rst  [2];
    logic       vld  [2];
    logic [3:0] din  [2];
    logic       rdy  [2];
    logic       sdo  [2];
    logic       bsy  [2];
    logic       done [2];

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(4), .BIT_CYC(4)) u_dut_a (
        .clk(clk), .r(rst[0]), .ld_valid(vld[0]), .D(din[0]),
        .ld_ready(rdy[0]), .sd(sdo[0]), .busy(bsy[0]), .tx_done(done[0])
    );
    piso_tx #(.WIDTH(4), .BIT_CYC(1)) u_dut_b (
        .clk(clk), .r(rst[1]), .ld_valid(vld[1]), .D(din[1]),
        .ld_ready(rdy[1]), .sd(sdo[1]), .busy(bsy[1]), .tx_done(done[1])
    );

`ifdef PISO_TX_PARITY_EN
    localparam int NBITS = 7;
`else
    localparam int NBITS = 6;
`endif

    typedef struct { int dut; logic [7:0] bits; logic [3:0] data; } exp_t;
    typedef struct { string name; int act; int req; } chk_t;
    exp_t exp_q[$];
    chk_t chk_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] cap_sd  [2];
    logic [63:0] cap_rdy [2];
    int          cap_n   [2];

    function automatic int bc(int k);
        return (k == 0) ? 4 : 1;
    endfunction

    // Frame bits in transmit order (bit 0 = start bit).
    function automatic logic [7:0] exp_frame(logic [3:0] d);
        logic [7:0] f;
        f = 8'h00;
`ifdef PISO_TX_PARITY_EN
        case (d)
            4'hA: f = 8'b0101_0100;
            4'hB: f = 8'b0111_0110;
            4'h3: f = 8'b0100_0110;
            4'hC: f = 8'b0101_1000;
            4'h5: f = 8'b0100_1010;
            4'h6: f = 8'b0100_1100;
            4'h9: f = 8'b0101_0010;
            4'hF: f = 8'b0101_1110;
            default: f = 8'h00;
        endcase
`else
        case (d)
            4'hA: f = 8'b0011_0100;
            4'hB: f = 8'b0011_0110;
            4'h3: f = 8'b0010_0110;
            4'hC: f = 8'b0011_1000;
            4'h5: f = 8'b0010_1010;
            4'h6: f = 8'b0010_1100;
            4'h9: f = 8'b0011_0010;
            4'hF: f = 8'b0011_1110;
            default: f = 8'h00;
        endcase
`endif
        return f;
    endfunction

    task automatic check_frame(int k);
        int idx;
        exp_t e;
        int len;
        logic [63:0] want_sd;
        logic [63:0] want_rdy;
        logic [63:0] mask;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i].dut == k) idx = i;
        end
        n_tests++;
        if (idx < 0) begin
            n_fail++;
            $display("FAIL unexpected_frame dut%0d: got tx_done after %0d cycles, required no frame", k, cap_n[k]);
            return;
        end
        e = exp_q[idx];
        exp_q.delete(idx);
        len = NBITS * bc(k);
        if (cap_n[k] != len) begin
            n_fail++;
            $display("FAIL frame_len dut%0d d=%h: got %0d cycles, required %0d", k, e.data, cap_n[k], len);
        end
        want_sd  = '0;
        want_rdy = '0;
        mask     = '0;
        for (int i = 0; i < len; i++) begin
            want_sd[i]  = e.bits[i / bc(k)];
            want_rdy[i] = (i == len - 1);
            mask[i]     = 1'b1;
        end
        n_tests++;
        if ((cap_sd[k] & mask) != want_sd) begin
            n_fail++;
            $display("FAIL frame_sd dut%0d d=%h: got %h, required %h", k, e.data, cap_sd[k] & mask, want_sd);
        end
        n_tests++;
        if ((cap_rdy[k] & mask) != want_rdy) begin
            n_fail++;
            $display("FAIL frame_ld_ready dut%0d d=%h: got %h, required %h", k, e.data, cap_rdy[k] & mask, want_rdy);
        end
    endtask

    // Monitor: the only process that counts comparisons.
    always @(negedge clk) begin
        chk_t c;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            n_tests++;
            if (c.act != c.req) begin
                n_fail++;
                $display("FAIL %s: got %0d, required %0d", c.name, c.act, c.req);
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (bsy[k]) begin
                if (cap_n[k] < 64) begin
                    cap_sd[k][cap_n[k]]  = sdo[k];
                    cap_rdy[k][cap_n[k]] = rdy[k];
                end
                cap_n[k]++;
                if (done[k]) begin
                    check_frame(k);
                    cap_n[k]   = 0;
                    cap_sd[k]  = '0;
                    cap_rdy[k] = '0;
                end
            end else begin
                if (done[k]) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_done_idle dut%0d: got tx_done=1 with busy=0, required 0", k);
                end
                cap_n[k]   = 0;
                cap_sd[k]  = '0;
                cap_rdy[k] = '0;
            end
        end
    end

    task automatic check(string name, int act, int req);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.req  = req;
        chk_q.push_back(c);
    endtask

    task automatic wait_ready(int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rdy[k]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("ld_ready_timeout", 0, 1);
    endtask

    task automatic wait_idle(int k);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!bsy[k] && rdy[k]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    task automatic send(int k, logic [3:0] d, bit expect_frame);
        bit ok;
        exp_t e;
        wait_ready(k, ok);
        if (ok) begin
            vld[k] = 1'b1;
            din[k] = d;
            if (expect_frame) begin
                e.dut  = k;
                e.bits = exp_frame(d);
                e.data = d;
                exp_q.push_back(e);
            end
            @(negedge clk);
            vld[k] = 1'b0;
        end
    endtask

    initial begin
        bit ok;
        int gap;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            vld[k] = 1'b0;
            din[k] = 4'h0;
            cap_n[k] = 0;
            cap_sd[k] = '0;
            cap_rdy[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_sd", sdo[k], 1);
            check("reset_busy", bsy[k], 0);
            check("reset_ld_ready", rdy[k], 0);
            check("reset_tx_done", done[k], 0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        check("ready_after_reset_a", rdy[0], 1);
        check("ready_after_reset_b", rdy[1], 1);

        // Basic frames on the BIT_CYC=4 instance
        send(0, 4'hA, 1'b1);
        wait_idle(0);
        send(0, 4'hB, 1'b1);
        wait_idle(0);

        // Inputs wiggled while busy must not disturb the frame or cause an accept
        send(0, 4'h9, 1'b1);
        for (int i = 0; i < 17; i++) begin
            vld[0] = 1'b1;
            din[0] = (i % 2 == 1) ? 4'h6 : 4'hF;
            @(negedge clk);
        end
        vld[0] = 1'b0;
        wait_idle(0);

        // Reset during data bit 2 of 0x5, then a clean frame of 0x6
        send(0, 4'h5, 1'b0);
        repeat (13) @(negedge clk);
        check("pre_reset_bit2", sdo[0], 1);
        check("pre_reset_busy", bsy[0], 1);
        rst[0] = 1'b1;
        vld[0] = 1'b1;
        din[0] = 4'h3;
        @(negedge clk);
        check("abort_sd", sdo[0], 1);
        check("abort_busy", bsy[0], 0);
        check("abort_ld_ready", rdy[0], 0);
        check("abort_tx_done", done[0], 0);
        rst[0] = 1'b0;
        vld[0] = 1'b0;
        @(negedge clk);
        check("ready_after_abort", rdy[0], 1);
        send(0, 4'h6, 1'b1);
        wait_idle(0);

        // BIT_CYC=1 instance: single frame then back-to-back pair
        send(1, 4'hF, 1'b1);
        wait_idle(1);
        wait_ready(1, ok);
        vld[1] = 1'b1;
        din[1] = 4'h3;
        e.dut  = 1;
        e.bits = exp_frame(4'h3);
        e.data = 4'h3;
        exp_q.push_back(e);
        @(negedge clk);
        din[1] = 4'hC;
        gap = 1;
        while (!rdy[1] && gap < 50) begin
            @(negedge clk);
            gap++;
        end
        check("b2b_ready_cycle", gap, NBITS);
        e.bits = exp_frame(4'hC);
        e.data = 4'hC;
        exp_q.push_back(e);
        @(negedge clk);
        vld[1] = 1'b0;
        check("b2b_start_sd", sdo[1], 0);
        check("b2b_start_busy", bsy[1], 1);
        wait_idle(1);

        wait_idle(0);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 4: data word width in bits, legal range 2..16.
REQ-002 Parameter BIT_CYC, default 4: clock cycles per serial bit, legal range 1..255.
REQ-003 clk  input  1  Single clock; all state updates on the rising edge.
REQ-004 r  input  1  Reset; synchronous, active-high.
REQ-005 ld_valid  input  1  Parallel word offered on D.
REQ-006 D  input  WIDTH  Parallel data word; sampled only on an accept cycle.
REQ-007 ld_ready  output  1  Block can accept a word this cycle.
REQ-008 sd  output  1  Serial line; idles high.
REQ-009 busy  output  1  High while a frame is on sd.
REQ-010 tx_done  output  1  One-cycle pulse in the final cycle of the stop bit.

Function
REQ-011 The block SHALL accept a word on any rising edge where ld_valid=1 and ld_ready=1, and capture D into an internal shift register.
REQ-012 States SHALL be IDLE, START, DATA, PAR (only when the parity macro is defined), and STOP.
REQ-013 Transitions SHALL be: IDLE->START on accept; START->DATA after BIT_CYC cycles; DATA->PAR or STOP after WIDTH bits; PAR->STOP after BIT_CYC cycles; STOP->IDLE after BIT_CYC cycles, or STOP->START on a back-to-back accept.
REQ-014 Frame SHALL be: start bit 0, then WIDTH data bits LSB first, then the optional parity bit, then stop bit 1; each bit held on sd for exactly BIT_CYC cycles.
REQ-015 sd SHALL go to the start bit on the first cycle after the accept edge, a latency of 1 cycle.
REQ-016 sd SHALL be registered, SHALL be 1 in IDLE, and SHALL never glitch between bits.
REQ-017 ld_ready SHALL be 1 in IDLE and in the last cycle of STOP, and 0 otherwise.
REQ-018 A back-to-back accept in the last STOP cycle SHALL start the next frame with no idle gap.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 tx_done SHALL pulse in the last STOP cycle whether or not a back-to-back accept occurs.
REQ-021 The bit-period counter SHALL count 0..BIT_CYC-1 and wrap.
REQ-022 The data-bit counter SHALL be wide enough to count WIDTH bits without overflow.
REQ-023 Changes on D or ld_valid while ld_ready=0 SHALL be ignored and SHALL NOT alter the frame in flight.

Reset
REQ-024 While r=1 at a clock edge, the block SHALL go to IDLE and drive sd=1, busy=0, tx_done=0, ld_ready=0, and clear all counters and the shift register.
REQ-025 ld_ready SHALL rise on the first edge after r deasserts.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, with sd=1 from the next edge and no tx_done pulse.
REQ-027 Reset SHALL take priority over a simultaneous accept.

Configuration
REQ-028 With macro PISO_TX_PARITY_EN defined, the block SHALL insert an even-parity bit (XOR of the WIDTH data bits) after the data bits, lengthening the frame to (WIDTH+3)*BIT_CYC cycles.
REQ-029 Without PISO_TX_PARITY_EN, the PAR state and parity logic SHALL be absent, and the frame SHALL be (WIDTH+2)*BIT_CYC cycles.

Verification
REQ-030 Basic frame: WIDTH=4, BIT_CYC=4, no parity, D=4'hA accepted -> sd = 0,0,1,0,1,1, each held 4 cycles; tx_done pulses at cycle 24 after the accept; busy high for 24 cycles.
REQ-031 Parity frame: PISO_TX_PARITY_EN defined, D=4'hB -> sd = 0,1,1,0,1,1,1; parity bit = 1; frame length 28 cycles.
REQ-032 Back-to-back: ld_valid held high with D=4'h3 then 4'hC, BIT_CYC=1 -> second start bit immediately follows the first stop bit; ld_ready high only in cycle 6 of the first frame.
REQ-033 Reset mid-frame: r=1 during the DATA bit 2 of D=4'h5 -> sd=1, busy=0, ld_ready=0 next cycle; no tx_done; a new frame with D=4'h6 after reset is correct.
REQ-034 Ignore while busy: D toggled and ld_valid=1 during a frame of D=4'h9 -> transmitted bits remain 1,0,0,1.
REQ-035 BIT_CYC=1 minimum: D=4'hF -> sd = 0,1,1,1,1,1, one cycle each.
